// File: rtl/boot_loader_pkg.sv
// Shared boot-loader definitions: FSM encoding, default memory geometry,
// and the word-address helper used by the loader.
package boot_loader_pkg;

    localparam int          DEF_MEM_WORDS = 256;
    localparam logic [31:0] DEF_ADDR_BASE = 32'h0000_0000;

    typedef enum logic [2:0] {
        S_LEN   = 3'd0,
        S_DATA  = 3'd1,
        S_WRITE = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    // Byte address of word 'idx' relative to the load base.
    function automatic logic [31:0] word_addr(input logic [31:0] base, input logic [31:0] idx);
        return base + (idx << 2);
    endfunction

endpackage

// File: rtl/boot_loader_byte_packer.sv
// Assembles 4 consecutive bytes into one little-endian 32-bit word.
// The first byte accepted lands in bits [7:0]. next_word exposes the word
// as it will be once the current byte is taken, so the 4th byte can be
// consumed in the same cycle it arrives.
module byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [7:0]  in_byte,
    output logic [31:0] next_word,
    output logic        word_ready
);

    logic [31:0] word;
    logic [1:0]  idx;

    // Shifting in from the top leaves byte k at [8k+7:8k] after 4 bytes.
    assign next_word  = {in_byte, word[31:8]};
    assign word_ready = en && (idx == 2'd3);

    // Byte shift register and position counter; idx wraps after each word.
    always_ff @(posedge clk) begin
        if (reset) begin
            word <= '0;
            idx  <= '0;
        end else if (en) begin
            word <= next_word;
            idx  <= idx + 2'd1;
        end
    end

endmodule

// File: rtl/boot_loader.sv
// Boot-stream loader: reads a 32-bit word count header followed by that
// many words, writes each word to program memory, and holds the core in
// reset until the whole image is in place.
module boot_loader
    import boot_loader_pkg::*;
#(
    parameter int          MEM_WORDS = DEF_MEM_WORDS,
    parameter logic [31:0] ADDR_BASE = DEF_ADDR_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  in_byte,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_wr,
    output logic        core_reset,
    output logic        boot_done,
    output logic        boot_err
);

    // One extra value of headroom so widx can represent MEM_WORDS itself.
    localparam int IW = $clog2(MEM_WORDS + 1);

    state_t        state;
    logic [IW-1:0] widx;
    logic [31:0]   count;
    logic [31:0]   packed_word;
    logic          word_ready;
    logic          xfer;

    assign xfer = in_valid && in_ready;

    // Header and data share one packer; its index wraps cleanly between them.
    byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .en         (xfer),
        .in_byte    (in_byte),
        .next_word  (packed_word),
        .word_ready (word_ready)
    );

    // Load FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_LEN;
            widx       <= '0;
            count      <= '0;
            mem_addr   <= ADDR_BASE;
            mem_wdata  <= '0;
            mem_wr     <= 1'b0;
            in_ready   <= 1'b1;
            core_reset <= 1'b1;
            boot_done  <= 1'b0;
            boot_err   <= 1'b0;
        end else begin
            case (state)
                S_LEN: begin
                    if (word_ready) begin
                        // Full 32-bit compare so oversize counts never alias.
                        count <= packed_word;
                        if (packed_word == 32'd0) begin
                            state      <= S_DONE;
                            in_ready   <= 1'b0;
                            core_reset <= 1'b0;
                            boot_done  <= 1'b1;
                        end else if (packed_word > 32'(MEM_WORDS)) begin
                            state    <= S_ERR;
                            in_ready <= 1'b0;
                            boot_err <= 1'b1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (word_ready) begin
                        state     <= S_WRITE;
                        mem_wr    <= 1'b1;
                        in_ready  <= 1'b0;
                        mem_addr  <= word_addr(ADDR_BASE, 32'(widx));
                        mem_wdata <= packed_word;
                    end
                end
                S_WRITE: begin
                    mem_wr <= 1'b0;
                    widx   <= widx + 1'b1;
                    if (32'(widx) + 32'd1 == count) begin
                        state      <= S_DONE;
                        core_reset <= 1'b0;
                        boot_done  <= 1'b1;
                    end else begin
                        state    <= S_DATA;
                        in_ready <= 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_DONE;
                end
                S_ERR: begin
                    state <= S_ERR;
                end
                default: begin
                    state    <= S_ERR;
                    in_ready <= 1'b0;
                    boot_err <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader: expected writes go into a scoreboard as
// words are sent, and a negedge monitor pops and checks every mem_wr.
`timescale 1ns/1ps
module tb_boot_loader;

    localparam int          MW = 256;
    localparam logic [31:0] AB = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_wr;
    logic        core_reset;
    logic        boot_done;
    logic        boot_err;

    int   tests = 0;
    int   fails = 0;
    int   exp_idx = 0;
    wr_t  q[$];
    logic prev_wr = 1'b0;

    always #5 clk = ~clk;

    boot_loader #(.MEM_WORDS(MW), .ADDR_BASE(AB)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_byte    (in_byte),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wr     (mem_wr),
        .core_reset (core_reset),
        .boot_done  (boot_done),
        .boot_err   (boot_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard monitor: every write must be expected and single-cycle.
    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_wr", mem_addr, 32'hFFFF_FFFF);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", mem_addr, e.addr);
                chk("wr_data", mem_wdata, e.data);
            end
            chk("wr_single_cycle", {31'd0, prev_wr}, 32'd0);
        end
        prev_wr <= mem_wr;
    end

    task automatic do_reset(input logic [7:0] b, input logic v);
        reset    = 1'b1;
        in_byte  = b;
        in_valid = v;
        @(posedge clk); #1;
        reset    = 1'b0;
        in_valid = 1'b0;
        q.delete();
        exp_idx  = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int g;
        int guard;
        g = 0;
        guard = 0;
        if (gaps) begin
            while ($urandom_range(1, 0) == 1 && g < 8) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
                g++;
            end
        end
        in_byte  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        if (in_ready !== 1'b1) begin
            chk("ready_timeout", {31'd0, in_ready}, 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps);
        q.push_back({AB + 32'(exp_idx) * 32'd4, w});
        exp_idx++;
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gaps);
    endtask

    task automatic send_hdr(input logic [31:0] n, input bit gaps);
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], gaps);
    endtask

    initial begin
        reset = 1'b1; in_byte = 8'h00; in_valid = 1'b0;
        do_reset(8'h00, 1'b0);

        // Reset state
        chk("rst_in_ready",   {31'd0, in_ready},   32'd1);
        chk("rst_core_reset", {31'd0, core_reset}, 32'd1);
        chk("rst_boot_done",  {31'd0, boot_done},  32'd0);
        chk("rst_boot_err",   {31'd0, boot_err},   32'd0);
        chk("rst_mem_wr",     {31'd0, mem_wr},     32'd0);
        chk("rst_mem_addr",   mem_addr,            AB);
        chk("rst_mem_wdata",  mem_wdata,           32'd0);

        // Two-word stream, valid held high
        send_hdr(32'd2, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        chk("basic_wr_now",      {31'd0, mem_wr},     32'd1);
        chk("basic_core_rst_hi", {31'd0, core_reset}, 32'd1);
        @(posedge clk); #1;
        chk("basic_core_rst_lo", {31'd0, core_reset}, 32'd0);
        chk("basic_done",        {31'd0, boot_done},  32'd1);
        chk("basic_in_ready",    {31'd0, in_ready},   32'd0);
        chk("basic_q_empty",     q.size(),            32'd0);
        // Input after done is ignored
        in_byte = 8'h55; in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1; in_valid = 1'b0;
        chk("done_sticky", {31'd0, boot_done},  32'd1);
        chk("done_core",   {31'd0, core_reset}, 32'd0);

        // Zero-length header
        do_reset(8'h00, 1'b0);
        send_hdr(32'd0, 1'b0);
        chk("zero_done",  {31'd0, boot_done},  32'd1);
        chk("zero_core",  {31'd0, core_reset}, 32'd0);
        chk("zero_ready", {31'd0, in_ready},   32'd0);

        // Oversize header
        do_reset(8'h00, 1'b0);
        send_hdr(32'(MW + 1), 1'b0);
        in_byte = 8'hA5; in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1; in_valid = 1'b0;
        chk("err_flag",  {31'd0, boot_err},   32'd1);
        chk("err_core",  {31'd0, core_reset}, 32'd1);
        chk("err_ready", {31'd0, in_ready},   32'd0);
        chk("err_done",  {31'd0, boot_done},  32'd0);

        // Same stream with random valid gaps
        do_reset(8'h00, 1'b0);
        send_hdr(32'd2, 1'b1);
        send_word(32'h1234_5678, 1'b1);
        send_word(32'hDEAD_BEEF, 1'b1);
        @(posedge clk); #1;
        chk("gap_done",    {31'd0, boot_done}, 32'd1);
        chk("gap_q_empty", q.size(),           32'd0);

        // Reset mid-word with a byte presented in the reset cycle
        do_reset(8'h00, 1'b0);
        send_hdr(32'd2, 1'b0);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b0);
        do_reset(8'h02, 1'b1);
        chk("midrst_core", {31'd0, core_reset}, 32'd1);
        send_hdr(32'd2, 1'b0);
        send_word(32'h1234_5678, 1'b0);
        send_word(32'hDEAD_BEEF, 1'b0);
        @(posedge clk); #1;
        chk("midrst_done",    {31'd0, boot_done}, 32'd1);
        chk("midrst_q_empty", q.size(),           32'd0);

        // Full memory, incrementing pattern
        do_reset(8'h00, 1'b0);
        send_hdr(32'(MW), 1'b0);
        for (int i = 0; i < MW; i++) send_word(32'h1000_0000 + 32'(i), 1'b0);
        @(posedge clk); #1;
        chk("full_last_addr", mem_addr,            AB + 32'h3FC);
        chk("full_last_data", mem_wdata,           32'h1000_0000 + 32'(MW - 1));
        chk("full_done",      {31'd0, boot_done},  32'd1);
        chk("full_core",      {31'd0, core_reset}, 32'd0);
        chk("full_q_empty",   q.size(),            32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter MEM_WORDS, default 256: number of 32-bit words in the program memory.
REQ-002 Parameter ADDR_BASE, default 32'h0000_0000: byte address of the first loaded word.
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-005 in_byte  input  8  incoming boot-stream byte.
REQ-006 in_valid  input  1  in_byte is valid this cycle.
REQ-007 in_ready  output  1  loader accepts in_byte this cycle; a transfer occurs when in_valid and in_ready are both high.
REQ-008 mem_addr  output  32  byte address for the memory write.
REQ-009 mem_wdata  output  32  word to write to memory.
REQ-010 mem_wr  output  1  one-cycle memory write strobe.
REQ-011 core_reset  output  1  holds the rv32 core in reset while high.
REQ-012 boot_done  output  1  high once the load has completed.
REQ-013 boot_err  output  1  high when the stream header is invalid.

Function
REQ-014 Stream format: a 4-byte little-endian word count N, then N words of 4 bytes each, little-endian.
REQ-015 FSM states are S_LEN, S_DATA, S_WRITE, S_DONE and S_ERR.
REQ-016 S_LEN: in_ready=1; accepted bytes are assembled into the count register; on the 4th byte the FSM goes to S_DONE if N=0, to S_ERR if N>MEM_WORDS, otherwise to S_DATA.
REQ-017 S_DATA: in_ready=1; byte k (0..3) of the current word goes to bits [8k+7:8k]; on the 4th byte the FSM goes to S_WRITE.
REQ-018 S_WRITE lasts exactly one cycle: mem_wr=1, in_ready=0, mem_addr=ADDR_BASE+4*widx, mem_wdata=the assembled word.
REQ-019 On leaving S_WRITE, widx increments; the FSM goes to S_DONE if widx+1==N, else back to S_DATA.
REQ-020 Latency: if the 4th byte of a word is accepted at edge E, mem_wr is high for the cycle following E and is low at all other times.
REQ-021 in_valid=0 cycles stall the FSM with no state change; a partially assembled word or count is retained indefinitely.
REQ-022 S_DONE is terminal: boot_done=1, core_reset=0, in_ready=0; further input is ignored.
REQ-023 S_ERR is terminal: boot_err=1, core_reset=1, in_ready=0, mem_wr never asserted.
REQ-024 core_reset=1 in every state except S_DONE; it deasserts in the cycle after the final write cycle.
REQ-025 mem_addr and mem_wdata hold their last value outside S_WRITE; only mem_wr qualifies them.
REQ-026 widx width is clog2(MEM_WORDS+1); the count register is 32 bits so oversize counts are detected without truncation.
REQ-027 Maximum addresses: N=MEM_WORDS writes to ADDR_BASE+4*(MEM_WORDS-1); no address wrap is possible.

Reset
REQ-028 When reset is high at a clock edge, the next state is: S_LEN, byte index 0, widx 0, count 0, assembly register 0, mem_addr=ADDR_BASE, mem_wdata 0, mem_wr 0, in_ready 1, core_reset 1, boot_done 0, boot_err 0.
REQ-029 Reset mid-operation, including during S_WRITE, S_DONE or S_ERR, discards all progress, so the next stream restarts with a count header; the core is re-held in reset.
REQ-030 Reset takes priority over a simultaneous input transfer; the byte presented in that cycle is dropped.

Structure
REQ-031 State encodings and the default MEM_WORDS and ADDR_BASE values belong in the shared rv32 definitions include, so the SoC top and memory size stay consistent.
REQ-032 One sub-module is used: byte_packer, which shifts 4 bytes into a 32-bit little-endian word with a 2-bit index and a word_ready pulse; it serves both header and data assembly.
REQ-033 The SoC top connects core_reset ORed with the system reset to the rv32 reset, and muxes the memory address, write data and write strobe from boot_loader while core_reset is high.

Verification
REQ-034 Stream 02 00 00 00, 78 56 34 12, EF BE AD DE with in_valid held high -> writes 0x12345678 @0x0, then 0xDEADBEEF @0x4; core_reset falls one cycle after the 2nd mem_wr.
REQ-035 Header 00 00 00 00 -> no mem_wr; boot_done=1 and core_reset=0 one cycle after the 4th byte.
REQ-036 Header with N=MEM_WORDS+1 (0x101 for 256) -> boot_err=1, core_reset stays 1, in_ready=0, and no writes occur.
REQ-037 Random in_valid gaps (about 50% duty) on the REQ-034 stream -> identical writes and addresses; mem_wr is never high for more than 1 cycle.
REQ-038 Reset asserted after 2 data bytes, then a fresh REQ-034 stream -> exactly the same 2 writes; the stale partial word is never written.
REQ-039 N=MEM_WORDS with an incrementing pattern -> last write at ADDR_BASE+0x3FC; a scoreboard matches every word.
